// File: rtl/der_zero_cross_detector.sv
// Slope sign-reversal (peak/trough) detector on derivative samples, with threshold arming and hold-off.
// Optional armed-state timeout is built in when DER_ARM_TIMEOUT_EN is defined.
module der_zero_cross_detector #(
  parameter int IBITS    = 10,
  parameter int HOLDOFF  = 16,
  parameter int CNT_BITS = 16,
  parameter int TIMEOUT  = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    der_valid,
  input  logic signed [IBITS-1:0] der_in,
  input  logic [IBITS-2:0]        thr,
  output logic                    evt_pulse,
  output logic                    evt_dir,
  output logic [IBITS-1:0]        evt_mag,
  output logic [CNT_BITS-1:0]     evt_count,
  output logic                    armed,
  output logic                    timeout_pulse
);

  // One counter serves both hold-off (counts down) and armed timeout (counts up).
  localparam int LIMIT_MAX = (HOLDOFF > TIMEOUT) ? HOLDOFF : TIMEOUT;
  localparam int CW        = $clog2(LIMIT_MAX + 1);

  localparam logic [CW-1:0]       ONE_C   = CW'(1);
  localparam logic [CW-1:0]       ZERO_C  = CW'(0);
  localparam logic [IBITS-1:0]    ONE_I   = IBITS'(1);
  localparam logic [CNT_BITS-1:0] ONE_N   = CNT_BITS'(1);
  localparam logic [CNT_BITS-1:0] SAT_N   = {CNT_BITS{1'b1}};

`ifdef DER_ARM_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM_POS = 2'd1,
    ARM_NEG = 2'd2,
    HOLD    = 2'd3
  } state_t;

  // The most negative input maps to 2^(IBITS-1), which still fits unsigned.
  function automatic logic [IBITS-1:0] abs_mag(input logic signed [IBITS-1:0] v);
    logic [IBITS-1:0] r;
    r = v[IBITS-1] ? (~v + ONE_I) : v;
    return r;
  endfunction

  state_t                  state_r, state_nxt_s;
  logic [IBITS-1:0]        tracker_r, tracker_nxt_s;
  logic [CW-1:0]           cnt_r, cnt_nxt_s;
  logic                    evt_pulse_r, evt_pulse_nxt_s;
  logic                    evt_dir_r, evt_dir_nxt_s;
  logic [IBITS-1:0]        evt_mag_r, evt_mag_nxt_s;
  logic [CNT_BITS-1:0]     evt_count_r, evt_count_nxt_s;
  logic                    armed_r, armed_nxt_s;
  logic                    tmo_pulse_r, tmo_pulse_nxt_s;

  logic signed [IBITS-1:0] thr_pos_s, thr_neg_s;
  logic [IBITS-1:0]        mag_s;
  logic                    is_neg_s;
  logic                    tmo_hit_s;

  assign thr_pos_s = $signed({1'b0, thr});
  assign thr_neg_s = -thr_pos_s;
  assign mag_s     = abs_mag(der_in);
  assign is_neg_s  = der_in[IBITS-1];
  assign tmo_hit_s = TMO_EN && ((cnt_r + ONE_C) == CW'(TIMEOUT));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; a crossing outranks a timeout on the same sample.
  always_comb begin
    state_nxt_s = state_r;
    if (der_valid) begin
      case (state_r)
        IDLE: begin
          if (der_in >= thr_pos_s) begin
            state_nxt_s = ARM_POS;
          end else if (der_in <= thr_neg_s) begin
            state_nxt_s = ARM_NEG;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        ARM_POS: begin
          if (is_neg_s) begin
            state_nxt_s = HOLD;
          end else if (tmo_hit_s) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = ARM_POS;
          end
        end
        ARM_NEG: begin
          if (!is_neg_s) begin
            state_nxt_s = HOLD;
          end else if (tmo_hit_s) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = ARM_NEG;
          end
        end
        HOLD: begin
          if (cnt_r == ONE_C) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = HOLD;
          end
        end
        default: state_nxt_s = IDLE;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Output and datapath next values, keyed off the current/next state pair.
  always_comb begin
    tracker_nxt_s   = tracker_r;
    cnt_nxt_s       = cnt_r;
    evt_pulse_nxt_s = 1'b0;
    evt_dir_nxt_s   = evt_dir_r;
    evt_mag_nxt_s   = evt_mag_r;
    evt_count_nxt_s = evt_count_r;
    tmo_pulse_nxt_s = 1'b0;
    if (der_valid) begin
      case (state_r)
        IDLE: begin
          if (state_nxt_s != IDLE) begin
            tracker_nxt_s = mag_s;
            cnt_nxt_s     = ZERO_C;
          end else begin
            tracker_nxt_s = tracker_r;
          end
        end
        ARM_POS, ARM_NEG: begin
          if (state_nxt_s == HOLD) begin
            evt_pulse_nxt_s = 1'b1;
            evt_dir_nxt_s   = (state_r == ARM_POS);
            evt_mag_nxt_s   = tracker_r;
            evt_count_nxt_s = (evt_count_r == SAT_N) ? evt_count_r : evt_count_r + ONE_N;
            cnt_nxt_s       = CW'(HOLDOFF);
          end else if (state_nxt_s == IDLE) begin
            tmo_pulse_nxt_s = 1'b1;
            cnt_nxt_s       = ZERO_C;
          end else begin
            tracker_nxt_s = (mag_s > tracker_r) ? mag_s : tracker_r;
            cnt_nxt_s     = TMO_EN ? (cnt_r + ONE_C) : cnt_r;
          end
        end
        HOLD: begin
          if (state_nxt_s == IDLE) begin
            cnt_nxt_s = ZERO_C;
          end else begin
            cnt_nxt_s = cnt_r - ONE_C;
          end
        end
        default: cnt_nxt_s = ZERO_C;
      endcase
    end else begin
      cnt_nxt_s = cnt_r;
    end
    armed_nxt_s = (state_nxt_s == ARM_POS) || (state_nxt_s == ARM_NEG);
  end

  // Registered datapath and outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tracker_r   <= '0;
      cnt_r       <= '0;
      evt_pulse_r <= 1'b0;
      evt_dir_r   <= 1'b0;
      evt_mag_r   <= '0;
      evt_count_r <= '0;
      armed_r     <= 1'b0;
      tmo_pulse_r <= 1'b0;
    end else begin
      tracker_r   <= tracker_nxt_s;
      cnt_r       <= cnt_nxt_s;
      evt_pulse_r <= evt_pulse_nxt_s;
      evt_dir_r   <= evt_dir_nxt_s;
      evt_mag_r   <= evt_mag_nxt_s;
      evt_count_r <= evt_count_nxt_s;
      armed_r     <= armed_nxt_s;
      tmo_pulse_r <= tmo_pulse_nxt_s;
    end
  end

  assign evt_pulse     = evt_pulse_r;
  assign evt_dir       = evt_dir_r;
  assign evt_mag       = evt_mag_r;
  assign evt_count     = evt_count_r;
  assign armed         = armed_r;
  assign timeout_pulse = tmo_pulse_r;

endmodule

// File: tb/tb_der_zero_cross_detector.sv
// Bench for der_zero_cross_detector: sample-level behavioural model compared every cycle,
// plus directed literal checks. Timeout expectations follow DER_ARM_TIMEOUT_EN.
module tb_der_zero_cross_detector;

  localparam int IBITS = 10, HOLDOFF = 4, CNT_BITS = 4, TIMEOUT = 8;
  localparam int M_IDLE = 0, M_POS = 1, M_NEG = 2, M_HOLD = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic der_valid = 1'b0;
  logic signed [IBITS-1:0] der_in = '0;
  logic [IBITS-2:0] thr = '0;
  logic evt_pulse, evt_dir, armed, timeout_pulse;
  logic [IBITS-1:0] evt_mag;
  logic [CNT_BITS-1:0] evt_count;

  int n_checks = 0;
  int n_fail = 0;

  int mode = M_IDLE, peak = 0, left = 0, age = 0;
  int m_cnt = 0, m_mag = 0;
  int m_pulse = 0, m_dir = 0, m_tpulse = 0;

  der_zero_cross_detector #(
    .IBITS(IBITS), .HOLDOFF(HOLDOFF), .CNT_BITS(CNT_BITS), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .der_valid(der_valid), .der_in(der_in), .thr(thr),
    .evt_pulse(evt_pulse), .evt_dir(evt_dir), .evt_mag(evt_mag), .evt_count(evt_count),
    .armed(armed), .timeout_pulse(timeout_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: one call per valid sample, plain integer arithmetic.
  task automatic model_sample(input int d, input int t);
    int a;
    a = (d < 0) ? -d : d;
    if (mode == M_IDLE) begin
      if (d >= t) begin mode = M_POS; peak = a; age = 0; end
      else if (d <= -t) begin mode = M_NEG; peak = a; age = 0; end
    end else if (mode == M_POS || mode == M_NEG) begin
      if ((mode == M_POS && d < 0) || (mode == M_NEG && d >= 0)) begin
        m_pulse = 1;
        m_dir = (mode == M_POS) ? 1 : 0;
        m_mag = peak;
        m_cnt = (m_cnt + 1 > 15) ? 15 : m_cnt + 1;
        mode = M_HOLD;
        left = HOLDOFF;
      end else begin
        if (a > peak) peak = a;
        age++;
`ifdef DER_ARM_TIMEOUT_EN
        if (age == TIMEOUT) begin mode = M_IDLE; m_tpulse = 1; end
`endif
      end
    end else begin
      left--;
      if (left == 0) mode = M_IDLE;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      mode = M_IDLE; peak = 0; left = 0; age = 0;
      m_cnt = 0; m_mag = 0; m_pulse = 0; m_dir = 0; m_tpulse = 0;
    end else begin
      m_pulse = 0;
      m_tpulse = 0;
      if (der_valid) model_sample(int'(der_in), int'(thr));
    end
  end

  initial forever begin
    @(negedge clk);
    chk("cyc_evt_pulse", int'(evt_pulse), m_pulse);
    chk("cyc_evt_dir", int'(evt_dir), m_dir);
    chk("cyc_evt_mag", int'(evt_mag), m_mag);
    chk("cyc_evt_count", int'(evt_count), m_cnt);
    chk("cyc_armed", int'(armed), (mode == M_POS || mode == M_NEG) ? 1 : 0);
    chk("cyc_timeout_pulse", int'(timeout_pulse), m_tpulse);
  end

  task automatic drive(input logic v, input int d);
    @(negedge clk);
    der_valid = v;
    der_in = d[IBITS-1:0];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic hold_out();
    repeat (HOLDOFF) drive(1'b1, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_count", int'(evt_count), 0);
    chk("rst_armed", int'(armed), 0);
    #2 rst_n = 1'b1;
    thr = 9'd50;

    // Peak
    drive(1'b1, 10);  step(); chk("peak_below_thr", int'(armed), 0);
    drive(1'b1, 60);  step(); chk("peak_armed", int'(armed), 1);
    drive(1'b1, 120);
    drive(1'b1, 90);
    drive(1'b1, -5);  step();
    chk("peak_pulse", int'(evt_pulse), 1);
    chk("peak_dir", int'(evt_dir), 1);
    chk("peak_mag", int'(evt_mag), 120);
    chk("peak_count", int'(evt_count), 1);

    // Hold-off with invalid gaps
    for (int i = 0; i < HOLDOFF; i++) begin
      drive(1'b1, 300); step();
      chk("hold_no_arm", int'(armed), 0);
      drive(1'b0, 300);
    end
    drive(1'b1, 300); step(); chk("hold_fifth_arms", int'(armed), 1);
    drive(1'b0, -300); step();
    chk("gap_keeps_armed", int'(armed), 1);
    chk("gap_no_event", int'(evt_pulse), 0);
    drive(1'b1, -1); step();
    chk("gap_evt_mag", int'(evt_mag), 300);
    chk("gap_evt_count", int'(evt_count), 2);
    hold_out();

    // Trough with zero crossing, then extreme negative input
    drive(1'b1, -80);
    drive(1'b1, -200);
    drive(1'b1, 0); step();
    chk("trough_pulse", int'(evt_pulse), 1);
    chk("trough_dir", int'(evt_dir), 0);
    chk("trough_mag", int'(evt_mag), 200);
    hold_out();
    drive(1'b1, -512);
    drive(1'b1, 5); step();
    chk("extreme_mag", int'(evt_mag), 512);
    chk("extreme_count", int'(evt_count), 4);
    hold_out();

    // Counter saturation
    for (int k = 0; k < 17; k++) begin
      drive(1'b1, 100);
      drive(1'b1, -1); step();
      chk("sat_pulse", int'(evt_pulse), 1);
      hold_out();
    end
    chk("sat_count", int'(evt_count), 15);

    // Armed timeout (or its absence)
    drive(1'b1, 100);
    repeat (8) drive(1'b1, 20);
    step();
`ifdef DER_ARM_TIMEOUT_EN
    chk("tmo_pulse", int'(timeout_pulse), 1);
    chk("tmo_disarm", int'(armed), 0);
    chk("tmo_no_event", int'(evt_pulse), 0);
    drive(1'b1, 100);
    repeat (7) drive(1'b1, 20);
    drive(1'b1, -1); step();
    chk("tmo_cross_event", int'(evt_pulse), 1);
    chk("tmo_cross_no_tmo", int'(timeout_pulse), 0);
`else
    chk("notmo_pulse", int'(timeout_pulse), 0);
    chk("notmo_armed", int'(armed), 1);
    drive(1'b1, -1); step();
    chk("notmo_event", int'(evt_pulse), 1);
`endif
    hold_out();

    // thr = 0: zero sample arms positive
    thr = 9'd0;
    drive(1'b1, 0); step(); chk("thr0_arm", int'(armed), 1);
    drive(1'b1, -3); step();
    chk("thr0_dir", int'(evt_dir), 1);
    chk("thr0_mag", int'(evt_mag), 0);
    hold_out();

    // Asynchronous reset in the middle of ARM_POS
    thr = 9'd50;
    drive(1'b1, 100);
    drive(1'b0, 7);
    drive(1'b1, 20);
    drive(1'b0, 7);
    @(negedge clk);
    der_valid = 1'b1;
    #1 chk("pre_rst_armed", int'(armed), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_armed", int'(armed), 0);
    chk("async_rst_count", int'(evt_count), 0);
    chk("async_rst_mag", int'(evt_mag), 0);
    chk("async_rst_dir", int'(evt_dir), 0);
    chk("async_rst_pulse", int'(evt_pulse), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    drive(1'b0, 0); step(); chk("post_rst_armed", int'(armed), 0);
    drive(1'b1, 10); step(); chk("post_rst_idle", int'(armed), 0);
    drive(1'b0, 0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
